spi_transfer_controller: RTL and testbench

- Byte-level SPI master sequencer (mode 0: CPOL=0, CPHA=0) that drives the 8-bit shift_register control inputs.
- Accepts a TX byte on a valid/ready handshake, then parallel-loads the shift register.
- Generates SCLK and CS_N, issues one shift pulse per SCLK rising edge with the sampled MISO bit, then reads back the received byte.
- Sits between the host/register interface and shift_register. MOSI is wired at top level from shift_register o_serial.

---
 rtl/spi_transfer_controller.sv | 121 ++++++++++++
 tb/tb_spi_transfer_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transfer_controller.sv
// Byte-level SPI mode-0 master sequencer that drives an external 8-bit shift register.
// Accepts a TX byte on valid/ready, clocks 8 bits out and in, then returns the received byte.
module spi_transfer_controller #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_lsb_first,
  output logic       o_ready,
  output logic       o_busy,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic [1:0] o_sr_mode,
  output logic       o_sr_output_enable_n,
  output logic [7:0] o_sr_parallel,
  output logic       o_sr_serial,
  input  logic [7:0] i_sr_parallel
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, HIGH, LOW, HOLD, READ
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_cnt;
  logic [3:0] bit_cnt;
  logic       lsb_first_q;
  logic       div_last;
  logic       enter_high;
  logic       accept;
  logic       rx_done;
  logic [1:0] sr_mode_d;

  assign div_last   = (div_cnt == DIV_LAST);
  assign accept     = (state_q == IDLE) && i_valid;
  assign enter_high = (state_d == HIGH) && (state_q != HIGH);
  assign rx_done    = (state_q == READ) && (state_d == IDLE);

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = LOAD;
      LOAD:    state_d = SETUP;
      SETUP:   if (div_last) state_d = HIGH;
      HIGH:    if (div_last) state_d = (bit_cnt == 4'd7) ? HOLD : LOW;
      LOW:     if (div_last) state_d = HIGH;
      HOLD:    if (div_last) state_d = READ;
      READ:    if (div_cnt == 8'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Exactly one shift pulse per bit, issued in the first cycle of each SCLK high phase.
  always_comb begin
    sr_mode_d = MODE_HOLD;
    if (state_d == LOAD)  sr_mode_d = MODE_LOAD;
    else if (enter_high)  sr_mode_d = lsb_first_q ? MODE_RIGHT : MODE_LEFT;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      div_cnt <= (state_d != state_q) ? 8'd0 : div_cnt + 8'd1;
      if (state_q == LOAD)
        bit_cnt <= '0;
      else if ((state_q == HIGH) && (state_d != HIGH))
        bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lsb_first_q          <= 1'b0;
      o_ready              <= 1'b1;
      o_busy               <= 1'b0;
      o_sclk               <= 1'b0;
      o_cs_n               <= 1'b1;
      o_sr_mode            <= MODE_HOLD;
      o_sr_output_enable_n <= 1'b1;
      o_sr_parallel        <= '0;
      o_sr_serial          <= 1'b0;
      o_rx_data            <= '0;
      o_rx_valid           <= 1'b0;
    end else begin
      if (accept) begin
        o_sr_parallel <= i_data;
        lsb_first_q   <= i_lsb_first;
      end
      if (enter_high)
        o_sr_serial <= i_miso;
      o_ready              <= (state_d == IDLE);
      o_busy               <= (state_d != IDLE);
      o_sclk               <= (state_d == HIGH);
      o_cs_n               <= !(state_d inside {SETUP, HIGH, LOW, HOLD});
      o_sr_mode            <= sr_mode_d;
      o_sr_output_enable_n <= (state_d != READ);
      o_rx_valid           <= rx_done;
      if (rx_done)
        o_rx_data <= i_sr_parallel;
    end
  end

endmodule

// File: tb/tb_spi_transfer_controller.sv
// Scoreboard bench: lane 0 runs CLK_DIV=2, lane 1 runs CLK_DIV=1, each with a shift register model.
// Stimulus pushes expected transfers; a per-lane monitor pops and compares on o_rx_valid.
module tb_spi_transfer_controller;

  typedef struct packed {
    logic [7:0]  rx;
    logic [7:0]  mosi;
    logic        lsb;
    logic [31:0] hs_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] valid, lsb_in, ready, busy, rx_valid, miso, sclk, cs_n, oe_n, ser, mosi;
  logic [1:0] tb_lsb, slave_en, slave_bit;
  logic [7:0] data [2];
  logic [7:0] rx_data [2];
  logic [7:0] par_out [2];
  logic [7:0] par_in [2];
  logic [7:0] q [2];
  logic [7:0] slave_byte [2];
  logic [2:0] slave_idx [2];
  logic [1:0] mode [2];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       exp_q [2][$];

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int D = (g == 0) ? 2 : 1;

    spi_transfer_controller #(.CLK_DIV(D)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid[g]), .i_data(data[g]),
      .i_lsb_first(lsb_in[g]), .o_ready(ready[g]), .o_busy(busy[g]),
      .o_rx_data(rx_data[g]), .o_rx_valid(rx_valid[g]), .i_miso(miso[g]),
      .o_sclk(sclk[g]), .o_cs_n(cs_n[g]), .o_sr_mode(mode[g]),
      .o_sr_output_enable_n(oe_n[g]), .o_sr_parallel(par_out[g]),
      .o_sr_serial(ser[g]), .i_sr_parallel(par_in[g])
    );

    // Shift register model: 11 load, 01 right (serial into bit 7), 10 left (serial into bit 0).
    always @(posedge clk)
      case (mode[g])
        2'b11:   q[g] <= par_out[g];
        2'b01:   q[g] <= {ser[g], q[g][7:1]};
        2'b10:   q[g] <= {q[g][6:0], ser[g]};
        default: q[g] <= q[g];
      endcase

    assign mosi[g]      = tb_lsb[g] ? q[g][0] : q[g][7];
    assign par_in[g]    = oe_n[g] ? 8'h00 : q[g];
    assign slave_bit[g] = slave_byte[g][slave_idx[g]];
    assign miso[g]      = slave_en[g] ? slave_bit[g] : mosi[g];

    int         rises, shifts, loads, oe_low, bad_mode, rb_err, cs_rise_cyc;
    logic [7:0] mosi_bits;
    logic       sclk_prev = 1'b0;
    logic       cs_prev = 1'b1;
    logic       want_lsb;
    exp_t       e;

    initial forever begin
      @(negedge clk);
      want_lsb = (exp_q[g].size() > 0) ? exp_q[g][0].lsb : 1'b0;
      if (rst) begin
        rises = 0; shifts = 0; loads = 0; oe_low = 0; bad_mode = 0; rb_err = 0;
        cs_rise_cyc = 0; mosi_bits = 8'h00;
      end else begin
        if (sclk[g] && !sclk_prev) begin
          rises++;
          mosi_bits = {mosi_bits[6:0], mosi[g]};
        end
        if (!sclk[g] && sclk_prev) slave_idx[g] = slave_idx[g] + 3'd1;
        if (!cs_n[g] && cs_prev)   slave_idx[g] = 3'd0;
        if (cs_n[g] && !cs_prev)   cs_rise_cyc = cyc;
        if (mode[g] == 2'b01 || mode[g] == 2'b10) begin
          shifts++;
          if (mode[g] != (want_lsb ? 2'b01 : 2'b10)) bad_mode++;
        end
        if (mode[g] == 2'b11) loads++;
        if (!oe_n[g]) begin
          oe_low++;
          if (mode[g] != 2'b00) bad_mode++;
        end
        if (ready[g] == busy[g]) rb_err++;
        if (rx_valid[g]) begin
          if (exp_q[g].size() == 0) begin
            fail($sformatf("L%0d unexpected o_rx_valid with rx_data 0x%0h", g, rx_data[g]));
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("L%0d rx_data", g), 32'(rx_data[g]), 32'(e.rx));
            check($sformatf("L%0d latency", g), 32'(cyc) - e.hs_cyc - 32'd1, 32'(17 * D + 3));
            check($sformatf("L%0d sclk_rises", g), 32'(rises), 32'd8);
            check($sformatf("L%0d shift_pulses", g), 32'(shifts), 32'd8);
            check($sformatf("L%0d bad_mode_cycles", g), 32'(bad_mode), 32'd0);
            check($sformatf("L%0d mosi_bits", g), 32'(mosi_bits), 32'(e.mosi));
            check($sformatf("L%0d load_cycles", g), 32'(loads), 32'd1);
            check($sformatf("L%0d oe_low_cycles", g), 32'(oe_low), 32'd2);
            check($sformatf("L%0d cs_rise_to_rx", g), 32'(cyc - cs_rise_cyc), 32'd2);
            check($sformatf("L%0d ready_busy_clash", g), 32'(rb_err), 32'd0);
            check($sformatf("L%0d ready_with_rx", g), 32'(ready[g]), 32'd1);
          end
          rises = 0; shifts = 0; loads = 0; oe_low = 0; bad_mode = 0; rb_err = 0;
          mosi_bits = 8'h00;
        end
      end
      sclk_prev = sclk[g];
      cs_prev   = cs_n[g];
    end
  end

  task automatic send(input int l, input logic [7:0] d, input logic lsb, input logic [7:0] exp_rx,
                      input logic expect_rx, input logic keep, output logic rxv_at_hs);
    exp_t e;
    logic ok;
    ok = 1'b0;
    rxv_at_hs = 1'b0;
    valid[l] = 1'b1; data[l] = d; lsb_in[l] = lsb; tb_lsb[l] = lsb;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = ready[l];
    end
    if (!ok) begin
      fail($sformatf("L%0d handshake timeout for 0x%0h", l, d));
      valid[l] = 1'b0;
      return;
    end
    rxv_at_hs = rx_valid[l];
    if (expect_rx) begin
      e.rx = exp_rx; e.mosi = lsb ? rev8(d) : d; e.lsb = lsb; e.hs_cyc = 32'(cyc);
      exp_q[l].push_back(e);
    end
    @(posedge clk); #1;
    if (!keep) valid[l] = 1'b0;
  endtask

  task automatic wait_idle(input int l);
    for (int i = 0; i < 600 && exp_q[l].size() > 0; i++) @(negedge clk);
    if (exp_q[l].size() > 0) fail($sformatf("L%0d o_rx_valid timeout", l));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rxv;
    logic prev;
    int   n;
    rst = 1'b1; valid = '0; lsb_in = '0; tb_lsb = '0; slave_en = '0;
    for (int l = 0; l < 2; l++) begin
      data[l] = 8'h00; slave_byte[l] = 8'h00; slave_idx[l] = 3'd0;
    end
    repeat (16) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("L%0d reset cs_n", l), 32'(cs_n[l]), 32'd1);
      check($sformatf("L%0d reset sclk", l), 32'(sclk[l]), 32'd0);
      check($sformatf("L%0d reset sr_mode", l), 32'(mode[l]), 32'd0);
      check($sformatf("L%0d reset ready", l), 32'(ready[l]), 32'd1);
      check($sformatf("L%0d reset busy", l), 32'(busy[l]), 32'd0);
      check($sformatf("L%0d reset rx_data", l), 32'(rx_data[l]), 32'd0);
      check($sformatf("L%0d reset rx_valid", l), 32'(rx_valid[l]), 32'd0);
      check($sformatf("L%0d reset oe_n", l), 32'(oe_n[l]), 32'd1);
    end
    @(posedge clk); #1;

    // MSB-first loopback
    send(0, 8'hA5, 1'b0, 8'hA5, 1'b1, 1'b0, rxv);
    wait_idle(0);

    // LSB-first against a slave that returns 0x81
    slave_byte[0] = 8'h81;
    slave_en[0]   = 1'b1;
    send(0, 8'h3C, 1'b1, 8'h81, 1'b1, 1'b0, rxv);
    wait_idle(0);
    slave_en[0] = 1'b0;

    // Back-to-back with i_valid held high; i_data and i_lsb_first disturbed mid-transfer
    send(0, 8'h11, 1'b0, 8'h11, 1'b1, 1'b1, rxv);
    repeat (10) @(posedge clk);
    #1 data[0] = 8'hEE; lsb_in[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 data[0] = 8'h22; lsb_in[0] = 1'b0;
    send(0, 8'h22, 1'b0, 8'h22, 1'b1, 1'b0, rxv);
    check("L0 b2b handshake on rx_valid cycle", 32'(rxv), 32'd1);
    wait_idle(0);

    // Reset after the 3rd SCLK rising edge; the partial byte must vanish
    send(0, 8'h96, 1'b0, 8'h00, 1'b0, 1'b0, rxv);
    n = 0;
    prev = 1'b0;
    for (int i = 0; i < 400 && n < 3; i++) begin
      @(negedge clk);
      if (sclk[0] && !prev) n++;
      prev = sclk[0];
    end
    check("L0 midrst 3rd sclk rise seen", 32'(n), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("L0 midrst cs_n", 32'(cs_n[0]), 32'd1);
    check("L0 midrst sclk", 32'(sclk[0]), 32'd0);
    check("L0 midrst sr_mode", 32'(mode[0]), 32'd0);
    check("L0 midrst rx_valid", 32'(rx_valid[0]), 32'd0);
    check("L0 midrst busy", 32'(busy[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, 8'h5A, 1'b0, 8'h5A, 1'b1, 1'b0, rxv);
    wait_idle(0);

    // CLK_DIV=1 lane
    send(1, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0, rxv);
    wait_idle(1);
    send(1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, rxv);
    wait_idle(1);

    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
